// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right, shift left and parallel load,
// with a saturating shift counter and a registered word-complete flag.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             din,
  input  logic                         sin_l,
  input  logic                         sin_r,
  output logic [WIDTH-1:0]             qout,
  output logic                         sout_l,
  output logic                         sout_r,
  output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
  output logic                         done
);

  localparam int            CW      = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] shr_word, shl_word;

  // Per-bit neighbour selection for both shift directions.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH-1) begin : g_shr_msb
        assign shr_word[gi] = sin_l;
      end else begin : g_shr_mid
        assign shr_word[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_shl_lsb
        assign shl_word[gi] = sin_r;
      end else begin : g_shl_mid
        assign shl_word[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    cnt_inc  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CW'(1);
    if (clr) begin
      q_next   = RST_VAL;
      cnt_next = '0;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_SHR: begin
          q_next   = shr_word;
          cnt_next = cnt_inc;
        end
        MODE_SHL: begin
          q_next   = shl_word;
          cnt_next = cnt_inc;
        end
        MODE_LOAD: begin
          q_next   = din;
          cnt_next = '0;
        end
        default: ;
      endcase
    end
    // Flag follows the next count so it rises with the WIDTH-th shift.
    done_next = (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg    <= RST_VAL;
      cnt_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      cnt_reg  <= cnt_next;
      done_reg <= done_next;
    end
  end

  assign qout      = q_reg;
  assign sout_l    = q_reg[WIDTH-1];
  assign sout_r    = q_reg[0];
  assign shift_cnt = cnt_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8, RST_VAL=8'h00.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] din = 8'h00;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  logic [7:0] qout;
  logic       sout_l, sout_r;
  logic [3:0] shift_cnt;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .din(din),
    .sin_l(sin_l), .sin_r(sin_r), .qout(qout), .sout_l(sout_l),
    .sout_r(sout_r), .shift_cnt(shift_cnt), .done(done)
  );

  always #5 clk = ~clk;

  // Applies one cycle of inputs and returns 1 time unit after the edge.
  task automatic step(input logic e, input logic c, input logic [1:0] m,
                      input logic [7:0] d, input logic sl, input logic sr);
    en = e; clr = c; mode = m; din = d; sin_l = sl; sin_r = sr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (qout !== 8'h00 || done !== 1'b0 || shift_cnt !== 4'd0 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
      $display("FAIL reset_init: qout=%h done=%b cnt=%0d sl=%b sr=%b, want 00 0 0 0 0", qout, done, shift_cnt, sout_l, sout_r);
      miscompares++;
    end
    #1 rst = 1'b0;
    step(1, 0, 2'b11, 8'hA5, 0, 0);
    vectors++;
    if (qout !== 8'hA5 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      $display("FAIL load_a5: qout=%h cnt=%0d done=%b, want a5 0 0", qout, shift_cnt, done);
      miscompares++;
    end
    vectors++;
    if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
      $display("FAIL sout_a5: sl=%b sr=%b, want 1 1", sout_l, sout_r);
      miscompares++;
    end
    // Async reset while register holds a nonzero word, no clock edge in between.
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (qout !== 8'h00 || done !== 1'b0 || shift_cnt !== 4'd0) begin
      $display("FAIL reset_async: qout=%h done=%b cnt=%0d, want 00 0 0", qout, done, shift_cnt);
      miscompares++;
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_deser_right;
    logic [7:0] bits;
    logic [7:0] exp_q [8];
    bits = 8'b0100_1101; // sin_l sequence 1,0,1,1,0,0,1,0 taken LSB first
    exp_q[0] = 8'h80; exp_q[1] = 8'h40; exp_q[2] = 8'hA0; exp_q[3] = 8'hD0;
    exp_q[4] = 8'h68; exp_q[5] = 8'h34; exp_q[6] = 8'h9A; exp_q[7] = 8'h4D;
    step(1, 1, 2'b00, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 2'b01, 8'h00, bits[i], 0);
      vectors++;
      if (qout !== exp_q[i] || shift_cnt !== 4'(i+1) || done !== (i == 7)) begin
        $display("FAIL deser_shift%0d: qout=%h cnt=%0d done=%b, want %h %0d %b",
                 i+1, qout, shift_cnt, done, exp_q[i], i+1, (i == 7));
        miscompares++;
      end
    end
    step(1, 0, 2'b01, 8'h00, 0, 0);
    vectors++;
    if (qout !== 8'h26 || shift_cnt !== 4'd8 || done !== 1'b1) begin
      $display("FAIL deser_saturate: qout=%h cnt=%0d done=%b, want 26 8 1", qout, shift_cnt, done);
      miscompares++;
    end
  endtask

  task automatic test_ser_left;
    logic [7:0] exp_sl;
    exp_sl = 8'b1100_0011; // expected sout_l sequence, MSB first
    step(1, 0, 2'b11, 8'hC3, 0, 0);
    vectors++;
    if (qout !== 8'hC3 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      $display("FAIL ser_load: qout=%h cnt=%0d done=%b, want c3 0 0", qout, shift_cnt, done);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (sout_l !== exp_sl[7-i]) begin
        $display("FAIL ser_sout_l%0d: sout_l=%b, want %b", i, sout_l, exp_sl[7-i]);
        miscompares++;
      end
      step(1, 0, 2'b10, 8'h00, 0, 0);
    end
    vectors++;
    if (qout !== 8'h00 || shift_cnt !== 4'd8 || done !== 1'b1) begin
      $display("FAIL ser_final: qout=%h cnt=%0d done=%b, want 00 8 1", qout, shift_cnt, done);
      miscompares++;
    end
  endtask

  task automatic test_enable_hold;
    step(1, 0, 2'b11, 8'h3C, 0, 0);
    step(1, 0, 2'b01, 8'h00, 0, 0);
    step(1, 0, 2'b01, 8'h00, 0, 0);
    vectors++;
    if (qout !== 8'h0F || shift_cnt !== 4'd2) begin
      $display("FAIL hold_pre: qout=%h cnt=%0d, want 0f 2", qout, shift_cnt);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'b01, 8'h00, 1, 1);
      vectors++;
      if (qout !== 8'h0F || shift_cnt !== 4'd2 || done !== 1'b0) begin
        $display("FAIL hold_en0_%0d: qout=%h cnt=%0d done=%b, want 0f 2 0", i, qout, shift_cnt, done);
        miscompares++;
      end
    end
    step(0, 0, 2'b11, 8'hFF, 0, 0);
    vectors++;
    if (qout !== 8'h0F || shift_cnt !== 4'd2) begin
      $display("FAIL hold_en0_load: qout=%h cnt=%0d, want 0f 2", qout, shift_cnt);
      miscompares++;
    end
    step(1, 0, 2'b01, 8'h00, 1, 0);
    vectors++;
    if (qout !== 8'h87 || shift_cnt !== 4'd3) begin
      $display("FAIL hold_resume: qout=%h cnt=%0d, want 87 3", qout, shift_cnt);
      miscompares++;
    end
  endtask

  task automatic test_direction;
    step(0, 1, 2'b00, 8'h00, 0, 0);
    step(1, 0, 2'b01, 8'h00, 1, 0);
    step(1, 0, 2'b01, 8'h00, 1, 0);
    step(1, 0, 2'b10, 8'h00, 0, 1);
    vectors++;
    if (qout !== 8'h81 || shift_cnt !== 4'd3) begin
      $display("FAIL dir_change: qout=%h cnt=%0d, want 81 3", qout, shift_cnt);
      miscompares++;
    end
    step(1, 0, 2'b00, 8'hFF, 1, 1);
    vectors++;
    if (qout !== 8'h81 || shift_cnt !== 4'd3 || done !== 1'b0) begin
      $display("FAIL mode_hold: qout=%h cnt=%0d done=%b, want 81 3 0", qout, shift_cnt, done);
      miscompares++;
    end
  endtask

  task automatic test_clear;
    step(1, 1, 2'b11, 8'hFF, 0, 0);
    vectors++;
    if (qout !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      $display("FAIL clr_vs_load: qout=%h cnt=%0d done=%b, want 00 0 0", qout, shift_cnt, done);
      miscompares++;
    end
    for (int i = 0; i < 8; i++) step(1, 0, 2'b01, 8'h00, 1, 0);
    vectors++;
    if (qout !== 8'hFF || done !== 1'b1) begin
      $display("FAIL clr_prefill: qout=%h done=%b, want ff 1", qout, done);
      miscompares++;
    end
    step(0, 1, 2'b01, 8'h00, 1, 0);
    vectors++;
    if (qout !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      $display("FAIL clr_en0: qout=%h cnt=%0d done=%b, want 00 0 0", qout, shift_cnt, done);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 8'h00, 1, 0);
    vectors++;
    if (qout !== 8'hF8 || shift_cnt !== 4'd5) begin
      $display("FAIL rstmid_pre: qout=%h cnt=%0d, want f8 5", qout, shift_cnt);
      miscompares++;
    end
    #3 rst = 1'b1;
    #1;
    vectors++;
    if (qout !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
      $display("FAIL rstmid_async: qout=%h cnt=%0d done=%b, want 00 0 0", qout, shift_cnt, done);
      miscompares++;
    end
    #18;
    vectors++;
    if (qout !== 8'h00 || shift_cnt !== 4'd0) begin
      $display("FAIL rstmid_held: qout=%h cnt=%0d, want 00 0", qout, shift_cnt);
      miscompares++;
    end
    #1 rst = 1'b0;
    step(1, 0, 2'b01, 8'h00, 1, 0);
    vectors++;
    if (qout !== 8'h80 || shift_cnt !== 4'd1) begin
      $display("FAIL rstmid_restart1: qout=%h cnt=%0d, want 80 1", qout, shift_cnt);
      miscompares++;
    end
    step(1, 0, 2'b01, 8'h00, 0, 0);
    vectors++;
    if (qout !== 8'h40 || shift_cnt !== 4'd2) begin
      $display("FAIL rstmid_restart2: qout=%h cnt=%0d, want 40 2", qout, shift_cnt);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_deser_right();
    test_ser_left();
    test_enable_hold();
    test_direction();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, want completion before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule
